// File: rtl/clk_ratio_ctrl.sv
// clk_ratio_ctrl: arbitrates host/sweep requests to reprogram the clk_gen divider and waits out the settle window.
// Optional feature macro: CLK_RATIO_CTRL_LOCK_EN (adds acq_active, which holds off new grants).
module clk_ratio_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter logic [7:0]  RESET_RATIO   = 8'd4
) (
  input  logic       clk_in_0,
  input  logic       rst_n,
  // Handshake: a requester raises *_req with *_ratio stable and holds both until its
  // one-cycle *_ack; it must drop req the cycle after ack or it is served again.
  input  logic       h_req,
  input  logic [7:0] h_ratio,
  output logic       h_ack,
  input  logic       s_req,
  input  logic [7:0] s_ratio,
  output logic       s_ack,
`ifdef CLK_RATIO_CTRL_LOCK_EN
  input  logic       acq_active,
`endif
  output logic       gen_we,
  output logic [7:0] gen_cr,
  output logic [7:0] cur_ratio,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int unsigned    CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_IDLE   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_win;       // 0 = host, 1 = sweep
  logic [7:0]      r_ratio;
  logic            r_wr;
  logic            r_rej;
  logic            r_init;      // current operation is the post-reset load, never acked
  logic            r_ptr;       // round-robin preference: 0 = host, 1 = sweep
  logic [7:0]      r_gen_cr;
  logic [7:0]      r_cur_ratio;

  logic            w_block;
  logic            w_h_elig;
  logic            w_s_elig;
  logic            w_grant;
  logic            w_grant_s;
  logic [7:0]      w_sel_ratio;
  logic            w_invalid;
  logic            w_same;
  logic            w_write;

`ifdef CLK_RATIO_CTRL_LOCK_EN
  assign w_block = acq_active;
`else
  assign w_block = 1'b0;
`endif

  always_comb begin
    w_h_elig    = h_req & ~w_block;
    w_s_elig    = s_req & ~w_block;
    w_grant     = (r_state == ST_IDLE) & (w_h_elig | w_s_elig);
    w_grant_s   = w_s_elig & (~w_h_elig | r_ptr);
    w_sel_ratio = w_grant_s ? s_ratio : h_ratio;
    w_invalid   = w_sel_ratio[0] | (w_sel_ratio < 8'd2);
    w_same      = (w_sel_ratio == r_cur_ratio);
    w_write     = ~w_invalid & ~w_same;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:   w_next = ST_LOAD;
      ST_LOAD:   w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      ST_IDLE:   if (w_grant) w_next = w_write ? ST_LOAD : ST_DONE;
      default:   w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_in_0 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk_in_0 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= CNT_LOAD;
      r_win       <= 1'b0;
      r_ratio     <= RESET_RATIO;
      r_wr        <= 1'b1;
      r_rej       <= 1'b0;
      r_init      <= 1'b1;
      r_ptr       <= 1'b0;
      r_gen_cr    <= RESET_RATIO;
      r_cur_ratio <= RESET_RATIO;
    end else begin
      if (r_state == ST_LOAD)
        r_cnt <= CNT_LOAD;
      else if (r_state == ST_SETTLE)
        r_cnt <= r_cnt - CNT_ONE;

      if (w_grant) begin
        r_win   <= w_grant_s;
        r_ratio <= w_sel_ratio;
        r_rej   <= w_invalid;
        r_wr    <= w_write;
        r_init  <= 1'b0;
        r_ptr   <= ~w_grant_s;
        // gen_cr is presented with the strobe and then simply holds
        if (w_write) r_gen_cr <= w_sel_ratio;
      end

      if ((r_state == ST_DONE) && r_wr)
        r_cur_ratio <= r_ratio;
    end
  end

  always_comb begin
    gen_we    = (r_state == ST_LOAD);
    gen_cr    = r_gen_cr;
    cur_ratio = r_cur_ratio;
    busy      = (r_state != ST_IDLE);
    h_ack     = (r_state == ST_DONE) & ~r_init & ~r_win;
    s_ack     = (r_state == ST_DONE) & ~r_init &  r_win;
    err       = (r_state == ST_DONE) & r_rej;
    dbg_state = r_state;
  end

endmodule
